car_motion_sequencer: RTL and testbench
=======================================

// Module: car_motion_sequencer
// PURPOSE
//  Downstream consumer of the floor-request memory. Fetches target floors one at a time
//  via read_enable/read_pointer, then drives the car motor up/down floor by floor.
//  Holds the door open for a fixed interval at each target, then returns for the next request.
//  Sits between the request memory and the motor/door drivers.
// PARAMETERS
//  NUM_FLOORS   8   valid floors 0..NUM_FLOORS-1; at most 16
//  DEPTH        8   request memory entries; read pointer wraps modulo DEPTH
//  FLOOR_TICKS  50  clock cycles of travel per floor; at least 1
//  DOOR_TICKS   100 clock cycles the door stays open; at least 1
// PORTS
//  clk            in   1  system clock, rising edge
//  rst            in   1  asynchronous, active-high reset
//  mem_data       in   4  data_out of request memory (target floor)
//  wr_pointer_in  in   4  memory write pointer from upstream, used for empty detect
//  read_enable    out  1  memory read strobe, one cycle per fetch
//  read_pointer   out  4  memory read address; bits above log2(DEPTH) are 0
//  motor_up       out  1  drive car upward
//  motor_down     out  1  drive car downward
//  door_open      out  1  door actuator
//  current_floor  out  4  floor the car is at or last passed
//  busy           out  1  high in every state except IDLE
//  door_hold      in   1  exists only with DOOR_HOLD_EN; keeps the door open
// BEHAVIOUR
//  Reset: clock and reset are fixed as above. While rst is high, or at any point mid-operation:
//   - state = IDLE; rd_ptr = 0; target = 0; timers = 0
//   - all outputs 0; current_floor = 0 (car homes to floor 0)
//  Registered state machine, Moore outputs. empty = (rd_ptr == wr_pointer_in).
//  IDLE: when !empty, go to FETCH.
//  FETCH: read_enable = 1 and read_pointer = rd_ptr for exactly this one cycle; next state LOAD.
//   - Memory read data is valid one cycle after read_enable.
//  LOAD: target <= mem_data; rd_ptr <= (rd_ptr == DEPTH-1) ? 0 : rd_ptr + 1.
//   - target >= NUM_FLOORS: discard the entry; go to IDLE with no motion.
//   - target == current_floor: go to DOOR_OPEN.
//   - target > current_floor: go to MOVE_UP. Otherwise go to MOVE_DOWN.
//   - Travel timer loads FLOOR_TICKS-1.
//  MOVE_UP / MOVE_DOWN: motor_up / motor_down = 1; the timer decrements each cycle.
//   - At 0: current_floor steps by ±1. If the new floor == target, go to DOOR_OPEN;
//     otherwise reload the timer.
//   - motor_up and motor_down are never high together.
//  DOOR_OPEN: door_open = 1; door timer loads DOOR_TICKS-1 and counts down.
//   - At 0: go to IDLE. Motor is always off while door_open = 1.
//  Latency: IDLE -> FETCH -> LOAD -> MOVE occupy consecutive edges.
//   - motor is high 3 edges after non-empty is first sampled in IDLE.
//   - Per floor: FLOOR_TICKS cycles.
//  wr_pointer_in changing mid-trip has no effect until the next IDLE; requests are served FIFO.
// CONFIGURATION
//  DOOR_HOLD_EN defined:
//   - door_hold port exists.
//   - In DOOR_OPEN, door_hold = 1 reloads the door timer to DOOR_TICKS-1 every cycle,
//     so the door closes DOOR_TICKS cycles after door_hold falls.
//  DOOR_HOLD_EN undefined: no door_hold port; the door interval is fixed.
// STRUCTURE
//  Shared package elevator_pkg holds:
//   - state encodings: IDLE, FETCH, LOAD, MOVE_UP, MOVE_DOWN, DOOR_OPEN
//   - floor width (4) and pointer width (4)
//  One sub-module, interval_timer: loadable down-counter with a zero flag.
//   - Instantiated twice, once for travel and once for the door.
// TESTING (FLOOR_TICKS=4, DOOR_TICKS=3, DEPTH=8)
//  1. Reset mid-move (car at floor 2, motor_up=1), pulse rst
//     -> all outputs 0, current_floor=0, read_pointer=0 on the same cycle.
//  2. mem[0]=3, wr_pointer_in=1 from floor 0
//     -> one read_enable at ptr 0; motor_up high for 12 cycles; current_floor steps 1,2,3;
//        door_open for 3 cycles; then busy=0.
//  3. Car at 3, next entry =1
//     -> motor_down for 8 cycles, current_floor 2 then 1, then door opens.
//  4. Entry = current floor (1)
//     -> no motor; door_open 3 cycles directly after LOAD.
//     Entry = 9 (out of range) -> discarded; rd_ptr advances; motor and door stay 0.
//  5. Eight entries written, wr_pointer_in wraps 7 -> 0
//     -> read_pointer goes 0..7 then 0; each entry is served exactly once, in order.
//  6. With DOOR_HOLD_EN, door_hold high for 10 cycles during DOOR_OPEN
//     -> door closes 3 cycles after door_hold falls.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared definitions for the car motion sequencer.
//   FLOOR_W / PTR_W : widths of floor numbers and request-memory pointers
//   IDLE..DOOR_OPEN : sequencer state encodings
//   ptr_next()      : read-pointer increment that wraps at the memory depth
package elevator_pkg;

   localparam int FLOOR_W = 4;
   localparam int PTR_W   = 4;

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] FETCH     = 3'd1;
   localparam logic [2:0] LOAD      = 3'd2;
   localparam logic [2:0] MOVE_UP   = 3'd3;
   localparam logic [2:0] MOVE_DOWN = 3'd4;
   localparam logic [2:0] DOOR_OPEN = 3'd5;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr,
                                                  input int depth);
      return (ptr == PTR_W'(depth - 1)) ? '0 : ptr + PTR_W'(1);
   endfunction

endpackage

// File: rtl/car_motion_sequencer_if.sv
// Signal bundle between the car motion sequencer and its environment
// (request memory on one side, motor/door drivers on the other).
//   mem_data, wr_pointer_in        : from the request memory / upstream writer
//   read_enable, read_pointer      : memory read strobe and address
//   motor_up, motor_down, door_open: actuator drives
//   current_floor, busy            : status
//   door_hold                      : present only when DOOR_HOLD_EN is defined
// Modports: master = sequencer side, slave = environment side.
interface car_motion_sequencer_if;
   import elevator_pkg::*;

   logic [FLOOR_W-1:0] mem_data;
   logic [PTR_W-1:0]   wr_pointer_in;
   logic               read_enable;
   logic [PTR_W-1:0]   read_pointer;
   logic               motor_up;
   logic               motor_down;
   logic               door_open;
   logic [FLOOR_W-1:0] current_floor;
   logic               busy;
`ifdef DOOR_HOLD_EN
   logic               door_hold;

   modport master (input  mem_data, wr_pointer_in, door_hold,
                   output read_enable, read_pointer, motor_up, motor_down,
                          door_open, current_floor, busy);
   modport slave  (output mem_data, wr_pointer_in, door_hold,
                   input  read_enable, read_pointer, motor_up, motor_down,
                          door_open, current_floor, busy);
`else
   modport master (input  mem_data, wr_pointer_in,
                   output read_enable, read_pointer, motor_up, motor_down,
                          door_open, current_floor, busy);
   modport slave  (output mem_data, wr_pointer_in,
                   input  read_enable, read_pointer, motor_up, motor_down,
                          door_open, current_floor, busy);
`endif

endinterface

// File: rtl/interval_timer.sv
// Loadable down-counter with a zero flag. Load wins over decrement; the
// count parks at zero rather than wrapping.
//   clk, rst   : clock, async active-high reset (count -> 0)
//   load       : load load_value this edge
//   load_value : reload value
//   dec        : decrement this edge
//   zero       : count == 0
module interval_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/car_motion_sequencer.sv
// Car motion sequencer: fetches target floors from the request memory one at
// a time, moves the car floor by floor, then holds the door open.
//   clk, rst : clock, async active-high reset (car homes to floor 0)
//   bus      : car_motion_sequencer_if.master (memory read port, wr pointer,
//              motor/door drives, current_floor, busy)
// Optional build macro DOOR_HOLD_EN: adds bus.door_hold, which keeps the door
// open by reloading the door timer every cycle it is high.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for a request (rd_ptr != wr_pointer_in)
// FETCH     | read strobe for entry rd_ptr
// LOAD      | memory data valid; latch target, pick direction
// MOVE_UP   | motor up, one floor per FLOOR_TICKS cycles
// MOVE_DOWN | motor down, one floor per FLOOR_TICKS cycles
// DOOR_OPEN | door open for DOOR_TICKS cycles
module car_motion_sequencer #(
   parameter int NUM_FLOORS  = 8,
   parameter int DEPTH       = 8,
   parameter int FLOOR_TICKS = 50,
   parameter int DOOR_TICKS  = 100
) (
   input  logic                   clk,
   input  logic                   rst,
   car_motion_sequencer_if.master bus
);
   import elevator_pkg::*;

   localparam int TW_F = (FLOOR_TICKS > 1) ? $clog2(FLOOR_TICKS) : 1;
   localparam int TW_D = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
   localparam logic [FLOOR_W:0] NF_LIMIT = (FLOOR_W + 1)'(NUM_FLOORS);

   logic [2:0]         state, state_nxt;
   logic [PTR_W-1:0]   rd_ptr;
   logic [FLOOR_W-1:0] target;
   logic [FLOOR_W-1:0] floor_q;
   logic [FLOOR_W-1:0] floor_step;
   logic               empty;
   logic               in_range;
   logic               moving;
   logic               trav_load, trav_zero;
   logic               door_load, door_zero;

   assign empty      = (rd_ptr == bus.wr_pointer_in);
   assign in_range   = ({1'b0, bus.mem_data} < NF_LIMIT);
   assign moving     = (state == MOVE_UP) || (state == MOVE_DOWN);
   assign floor_step = (state == MOVE_DOWN) ? floor_q - FLOOR_W'(1)
                                            : floor_q + FLOOR_W'(1);

   always_comb begin
      state_nxt = state;
      trav_load = 1'b0;
      door_load = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) state_nxt = FETCH;
         end
         FETCH: begin
            state_nxt = LOAD;
         end
         LOAD: begin
            trav_load = 1'b1;
            if (!in_range) begin
               state_nxt = IDLE;
            end else if (bus.mem_data == floor_q) begin
               state_nxt = DOOR_OPEN;
               door_load = 1'b1;
            end else if (bus.mem_data > floor_q) begin
               state_nxt = MOVE_UP;
            end else begin
               state_nxt = MOVE_DOWN;
            end
         end
         MOVE_UP, MOVE_DOWN: begin
            if (trav_zero) begin
               if (floor_step == target) begin
                  state_nxt = DOOR_OPEN;
                  door_load = 1'b1;
               end else begin
                  trav_load = 1'b1;
               end
            end
         end
         DOOR_OPEN: begin
`ifdef DOOR_HOLD_EN
            if (bus.door_hold) begin
               door_load = 1'b1;
            end else if (door_zero) begin
               state_nxt = IDLE;
            end
`else
            if (door_zero) state_nxt = IDLE;
`endif
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         rd_ptr  <= '0;
         target  <= '0;
         floor_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == LOAD) begin
            target <= bus.mem_data;
            rd_ptr <= ptr_next(rd_ptr, DEPTH);
         end
         if (moving && trav_zero) floor_q <= floor_step;
      end
   end

   interval_timer #(.WIDTH(TW_F)) u_travel_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (trav_load),
      .load_value (TW_F'(FLOOR_TICKS - 1)),
      .dec        (moving),
      .zero       (trav_zero)
   );

   interval_timer #(.WIDTH(TW_D)) u_door_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (door_load),
      .load_value (TW_D'(DOOR_TICKS - 1)),
      .dec        (state == DOOR_OPEN),
      .zero       (door_zero)
   );

   // Address is only presented during the fetch strobe.
   assign bus.read_enable   = (state == FETCH);
   assign bus.read_pointer  = (state == FETCH) ? rd_ptr : '0;
   assign bus.motor_up      = (state == MOVE_UP);
   assign bus.motor_down    = (state == MOVE_DOWN);
   assign bus.door_open     = (state == DOOR_OPEN);
   assign bus.current_floor = floor_q;
   assign bus.busy          = (state != IDLE);

endmodule

// File: tb/tb_car_motion_sequencer.sv
// Bench for car_motion_sequencer. A trip-level reference model turns each
// request into the expected per-cycle output trace (fetch, load, travel,
// door, idle), which is compared at every falling edge.
module tb_car_motion_sequencer;
   import elevator_pkg::*;

   localparam int NF  = 8;
   localparam int DEP = 8;
   localparam int FT  = 4;
   localparam int DT  = 3;
   localparam int DOOR_BIT = 5;

   logic clk = 1'b0;
   logic rst;

   car_motion_sequencer_if bus ();

   car_motion_sequencer #(
      .NUM_FLOORS  (NF),
      .DEPTH       (DEP),
      .FLOOR_TICKS (FT),
      .DOOR_TICKS  (DT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [3:0] mem [DEP];

   always @(posedge clk or posedge rst) begin
      if (rst) bus.mem_data <= '0;
      else if (bus.read_enable) bus.mem_data <= mem[bus.read_pointer[2:0]];
   end

`ifdef DOOR_HOLD_EN
   int   hold_len = 0;
   int   hold_left = 0;
   logic door_hold_tb = 1'b0;
   assign bus.door_hold = door_hold_tb;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   int m_floor = 0;
   int m_rptr  = 0;
   int m_wptr  = 0;
   int pend[$];
   logic [12:0] exp_q[$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // {read_enable, read_pointer, motor_up, motor_down, door_open, current_floor, busy}
   function automatic logic [12:0] obs_vec();
      return {bus.read_enable, bus.read_pointer, bus.motor_up, bus.motor_down,
              bus.door_open, bus.current_floor, bus.busy};
   endfunction

   function automatic logic [12:0] mk(input logic re, input int rp, input logic up,
                                      input logic dn, input logic door, input int fl,
                                      input logic busy);
      return {re, 4'(rp), up, dn, door, 4'(fl), busy};
   endfunction

   task automatic write_entry(input int val);
      mem[m_wptr] = 4'(val);
      m_wptr = (m_wptr + 1) % DEP;
      bus.wr_pointer_in = 4'(m_wptr);
      pend.push_back(val);
   endtask

   // Expected trace of one request, ending with the one mandatory idle cycle.
   task automatic gen_trip();
      int t, p, n, dir, nd;
      t = pend.pop_front();
      p = m_rptr;
      m_rptr = (m_rptr + 1) % DEP;
      exp_q.push_back(mk(1'b1, p, 1'b0, 1'b0, 1'b0, m_floor, 1'b1));
      exp_q.push_back(mk(1'b0, 0, 1'b0, 1'b0, 1'b0, m_floor, 1'b1));
      if (t < NF) begin
         dir = (t > m_floor) ? 1 : -1;
         n = (t > m_floor) ? t - m_floor : m_floor - t;
         for (int k = 0; k < n; k++)
            for (int c = 0; c < FT; c++)
               exp_q.push_back(mk(1'b0, 0, dir > 0, dir < 0, 1'b0, m_floor + dir * k, 1'b1));
         m_floor = t;
         nd = DT;
`ifdef DOOR_HOLD_EN
         nd = DT + hold_len;
`endif
         for (int c = 0; c < nd; c++)
            exp_q.push_back(mk(1'b0, 0, 1'b0, 1'b0, 1'b1, m_floor, 1'b1));
      end
      exp_q.push_back(mk(1'b0, 0, 1'b0, 1'b0, 1'b0, m_floor, 1'b0));
   endtask

   task automatic run_trips(input bit allow_mid);
      logic [12:0] v;
      while (pend.size() > 0) begin
         gen_trip();
         while (exp_q.size() > 0) begin
            @(negedge clk);
            v = exp_q.pop_front();
            check_val("trace", 32'(obs_vec()), 32'(v));
`ifdef DOOR_HOLD_EN
            if (hold_left > 0 && v[DOOR_BIT]) begin
               door_hold_tb = 1'b1;
               hold_left--;
            end else begin
               door_hold_tb = 1'b0;
            end
`endif
            if (allow_mid && pend.size() < 6 && $urandom_range(0, 15) == 0)
               write_entry(int'($urandom_range(0, 11)));
         end
      end
   endtask

   task automatic run_idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_val("idle", 32'(obs_vec()), 32'(mk(1'b0, 0, 1'b0, 1'b0, 1'b0, m_floor, 1'b0)));
      end
   endtask

   initial begin
      bit found;
      int nb;
      rst = 1'b1;
      bus.wr_pointer_in = '0;
      for (int i = 0; i < DEP; i++) mem[i] = '0;
      repeat (3) @(negedge clk);
      check_val("rst_out", 32'(obs_vec()), 32'(0));
      rst = 1'b0;
      run_idle(2);

      // Reset while travelling up through floor 2.
      mem[0] = 4'd5;
      bus.wr_pointer_in = 4'd1;
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.current_floor == 4'd2 && bus.motor_up) begin
            found = 1'b1;
            break;
         end
      end
      check_val("t1_reach", 32'(found), 32'(1));
      rst = 1'b1;
      #1;
      check_val("t1_rst", 32'(obs_vec()), 32'(0));
      bus.wr_pointer_in = '0;
      m_floor = 0;
      m_rptr  = 0;
      m_wptr  = 0;
      pend.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      run_idle(2);

      // Up 0->3, down 3->1, same floor, out-of-range discard.
      write_entry(3);
      write_entry(1);
      write_entry(1);
      write_entry(9);
      run_trips(1'b0);
      run_idle(2);

`ifdef DOOR_HOLD_EN
      hold_len  = 10;
      hold_left = 10;
      write_entry(m_floor + 1);
      run_trips(1'b0);
      hold_len = 0;
      door_hold_tb = 1'b0;
      run_idle(1);
`endif

      // Full batch of seven followed by more so the pointers wrap.
      for (int i = 0; i < 7; i++) write_entry(int'($urandom_range(0, 7)));
      run_trips(1'b0);
      write_entry(int'($urandom_range(0, 7)));
      run_trips(1'b0);

      for (int r = 0; r < 25; r++) begin
         run_idle(int'($urandom_range(1, 3)));
         nb = int'($urandom_range(1, 7));
         for (int i = 0; i < nb; i++) write_entry(int'($urandom_range(0, 11)));
         run_trips(1'b1);
      end
      run_idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, limit reached");
      $fatal(1, "timeout");
   end

endmodule
